// File: rtl/eclair_pkg.sv
// eclair_pkg
// Shared constants for the ECLair datapath cluster:
//   - ALU mode selects (arithmetic / logic)
//   - ALU function-select codes for the common microword operations
//   - register-load strobe indices driven by the 3-to-8 decoder
package eclair_pkg;

    typedef logic [3:0] alu_op_t;

    localparam logic ALU_MODE_ARITH = 1'b0;
    localparam logic ALU_MODE_LOGIC = 1'b1;

    // Arithmetic-mode function selects
    localparam alu_op_t ALU_ADD    = 4'h9;  // A + B + c_in
    localparam alu_op_t ALU_SUB    = 4'h6;  // A + ~B + c_in (A - B with c_in = 1)
    localparam alu_op_t ALU_DEC_A  = 4'hF;  // A + 0xFFFF + c_in
    localparam alu_op_t ALU_DBL_A  = 4'hC;  // A + A + c_in

    // Logic-mode function selects
    localparam alu_op_t ALU_PASS_A = 4'hF;
    localparam alu_op_t ALU_PASS_B = 4'hA;
    localparam alu_op_t ALU_ZERO   = 4'h3;
    localparam alu_op_t ALU_ONES   = 4'hC;
    localparam alu_op_t ALU_AND    = 4'hB;
    localparam alu_op_t ALU_OR     = 4'hE;
    localparam alu_op_t ALU_XOR    = 4'h6;

    // Register-load strobe indices (decoder outputs)
    localparam logic [2:0] LD_REG_A = 3'd0;
    localparam logic [2:0] LD_REG_B = 3'd1;
    localparam logic [2:0] LD_REG_C = 3'd2;
    localparam logic [2:0] LD_REG_D = 3'd3;

endpackage

// File: rtl/eclair_alu16.sv
// eclair_alu16
// Combinational 16-bit 74181-style ALU.
// Ports:
//   mode  in  1   0 = arithmetic, 1 = logic
//   op    in  4   function select S[3:0]
//   c_in  in  1   carry in (arithmetic only)
//   x, y  in  16  operands A, B
//   z     out 16  result
//   c_out out 1   carry out (always 0 in logic mode)
//   zero  out 1   high when z == 0
module eclair_alu16
    import eclair_pkg::*;
(
    input  logic        mode,
    input  alu_op_t     op,
    input  logic        c_in,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] z,
    output logic        c_out,
    output logic        zero
);

    logic [15:0] logic_z;
    logic [15:0] p_sel;
    logic [15:0] q_sel;
    logic [16:0] arith_sum;

    // Logic-mode function table
    always_comb begin
        logic_z = 16'h0000;
        case (op)
            4'h0: logic_z = ~x;
            4'h1: logic_z = ~(x | y);
            4'h2: logic_z = ~x & y;
            4'h3: logic_z = 16'h0000;
            4'h4: logic_z = ~(x & y);
            4'h5: logic_z = ~y;
            4'h6: logic_z = x ^ y;
            4'h7: logic_z = x & ~y;
            4'h8: logic_z = ~x | y;
            4'h9: logic_z = ~(x ^ y);
            4'hA: logic_z = y;
            4'hB: logic_z = x & y;
            4'hC: logic_z = 16'hFFFF;
            4'hD: logic_z = x | ~y;
            4'hE: logic_z = x | y;
            4'hF: logic_z = x;
            default: logic_z = 16'h0000;
        endcase
    end

    // Arithmetic mode is always P + Q + c_in; the op only chooses the two
    // addends, which mirrors how the 74181 generates its internal P/Q terms.
    always_comb begin
        p_sel = x;
        q_sel = 16'h0000;
        case (op)
            4'h0: begin p_sel = x;      q_sel = 16'h0000; end
            4'h1: begin p_sel = x | y;  q_sel = 16'h0000; end
            4'h2: begin p_sel = x | ~y; q_sel = 16'h0000; end
            4'h3: begin p_sel = 16'h0000; q_sel = 16'hFFFF; end
            4'h4: begin p_sel = x;      q_sel = x & ~y;   end
            4'h5: begin p_sel = x | y;  q_sel = x & ~y;   end
            4'h6: begin p_sel = x;      q_sel = ~y;       end
            4'h7: begin p_sel = x & ~y; q_sel = 16'hFFFF; end
            4'h8: begin p_sel = x;      q_sel = x & y;    end
            4'h9: begin p_sel = x;      q_sel = y;        end
            4'hA: begin p_sel = x | ~y; q_sel = x & y;    end
            4'hB: begin p_sel = x & y;  q_sel = 16'hFFFF; end
            4'hC: begin p_sel = x;      q_sel = x;        end
            4'hD: begin p_sel = x | y;  q_sel = x;        end
            4'hE: begin p_sel = x | ~y; q_sel = x;        end
            4'hF: begin p_sel = x;      q_sel = 16'hFFFF; end
            default: begin p_sel = x;   q_sel = 16'h0000; end
        endcase
    end

    assign arith_sum = {1'b0, p_sel} + {1'b0, q_sel} + {16'h0000, c_in};

    assign z     = (mode == ALU_MODE_LOGIC) ? logic_z : arith_sum[15:0];
    assign c_out = (mode == ALU_MODE_LOGIC) ? 1'b0    : arith_sum[16];
    assign zero  = (z == 16'h0000);

endmodule

// File: rtl/eclair_datapath_core.sv
// eclair_datapath_core
// ECLair datapath primitive cluster: 16-bit ALU, loadable program counter
// and the 3-to-8 register-load strobe decoder.
// Ports:
//   clk        in   1         system clock
//   _reset     in   1         synchronous active-low reset (PC only)
//   pc_inc     in   1         PC count enable
//   pc_load    in   1         PC parallel load (wins over pc_inc)
//   pc_preset  in   PC_WIDTH  PC load value
//   pc         out  PC_WIDTH  program counter
//   alu_*                     see eclair_alu16
//   dmx_en     in   1         decoder enable
//   dmx_sel    in   3         decoder select
//   dmx_out    out  8         one-hot register-load strobes
module eclair_datapath_core
    import eclair_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic                pc_inc,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_preset,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                alu_mode,
    input  logic [3:0]          alu_op,
    input  logic                alu_c_in,
    input  logic [15:0]         alu_x,
    input  logic [15:0]         alu_y,
    output logic [15:0]         alu_z,
    output logic                alu_c_out,
    output logic                alu_zero,
    input  logic                dmx_en,
    input  logic [2:0]          dmx_sel,
    output logic [7:0]          dmx_out
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] pc_reg;

    // Reset > load > increment > hold; increment wraps naturally.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            pc_reg <= '0;
        end else if (pc_load) begin
            pc_reg <= pc_preset;
        end else if (pc_inc) begin
            pc_reg <= pc_reg + PC_ONE;
        end
    end

    assign pc = pc_reg;

    eclair_alu16 u_alu (
        .mode  (alu_mode),
        .op    (alu_op),
        .c_in  (alu_c_in),
        .x     (alu_x),
        .y     (alu_y),
        .z     (alu_z),
        .c_out (alu_c_out),
        .zero  (alu_zero)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dmx
            assign dmx_out[gi] = dmx_en && (dmx_sel == 3'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_eclair_datapath_core.sv
module tb_eclair_datapath_core;

    logic        clk = 1'b0;
    logic        _reset = 1'b0;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_preset = 16'h0000;
    logic [15:0] pc;
    logic        alu_mode = 1'b1;
    logic [3:0]  alu_op = 4'h3;
    logic        alu_c_in = 1'b0;
    logic [15:0] alu_x = 16'h0000;
    logic [15:0] alu_y = 16'h0000;
    logic [15:0] alu_z;
    logic        alu_c_out;
    logic        alu_zero;
    logic        dmx_en = 1'b0;
    logic [2:0]  dmx_sel = 3'd0;
    logic [7:0]  dmx_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [15:0] pc;
        logic [15:0] z;
        logic        c;
        logic [7:0]  dmx;
        logic        verbose;
    } exp_t;

    exp_t sb[$];

    logic [15:0] hold_pc = 16'h0000;

    eclair_datapath_core #(.PC_WIDTH(16)) dut (
        .clk       (clk),
        ._reset    (_reset),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_preset (pc_preset),
        .pc        (pc),
        .alu_mode  (alu_mode),
        .alu_op    (alu_op),
        .alu_c_in  (alu_c_in),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_c_out (alu_c_out),
        .alu_zero  (alu_zero),
        .dmx_en    (dmx_en),
        .dmx_sel   (dmx_sel),
        .dmx_out   (dmx_out)
    );

    always #5 clk = ~clk;

    // Reference table for the random ALU section: returns {c_out, z}.
    function automatic logic [16:0] alu_model(input logic mode, input logic [3:0] op,
                                              input logic cin, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] p;
        logic [15:0] q;
        logic [15:0] l;
        p = 16'h0000;
        q = 16'h0000;
        l = 16'h0000;
        if (mode) begin
            case (op)
                4'h0: l = ~a;        4'h1: l = ~(a | b);
                4'h2: l = ~a & b;    4'h3: l = 16'h0000;
                4'h4: l = ~(a & b);  4'h5: l = ~b;
                4'h6: l = a ^ b;     4'h7: l = a & ~b;
                4'h8: l = ~a | b;    4'h9: l = ~(a ^ b);
                4'hA: l = b;         4'hB: l = a & b;
                4'hC: l = 16'hFFFF;  4'hD: l = a | ~b;
                4'hE: l = a | b;     default: l = a;
            endcase
            return {1'b0, l};
        end
        case (op)
            4'h0: begin p = a;      q = 16'h0000; end
            4'h1: begin p = a | b;  q = 16'h0000; end
            4'h2: begin p = a | ~b; q = 16'h0000; end
            4'h3: begin p = 16'h0;  q = 16'hFFFF; end
            4'h4: begin p = a;      q = a & ~b;   end
            4'h5: begin p = a | b;  q = a & ~b;   end
            4'h6: begin p = a;      q = ~b;       end
            4'h7: begin p = a & ~b; q = 16'hFFFF; end
            4'h8: begin p = a;      q = a & b;    end
            4'h9: begin p = a;      q = b;        end
            4'hA: begin p = a | ~b; q = a & b;    end
            4'hB: begin p = a & b;  q = 16'hFFFF; end
            4'hC: begin p = a;      q = a;        end
            4'hD: begin p = a | b;  q = a;        end
            4'hE: begin p = a | ~b; q = a;        end
            default: begin p = a;   q = 16'hFFFF; end
        endcase
        return 17'(p) + 17'(q) + 17'(cin);
    endfunction

    task automatic push(input int id, input logic [15:0] e_pc, input logic [15:0] e_z,
                        input logic e_c, input logic [7:0] e_dmx, input logic verbose);
        exp_t e;
        e.id = id; e.pc = e_pc; e.z = e_z; e.c = e_c; e.dmx = e_dmx; e.verbose = verbose;
        sb.push_back(e);
    endtask

    // e_pc is the PC expected during this cycle (result of the previous edge).
    task automatic pc_step(input int id, input logic rst_n, input logic inc, input logic load,
                           input logic [15:0] preset, input logic [15:0] e_pc);
        @(posedge clk); #1;
        _reset = rst_n; pc_inc = inc; pc_load = load; pc_preset = preset;
        alu_mode = 1'b1; alu_op = 4'h3; alu_c_in = 1'b0; alu_x = 16'h1234; alu_y = 16'h5678;
        dmx_en = 1'b0; dmx_sel = 3'd0;
        push(id, e_pc, 16'h0000, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic alu_step(input int id, input logic mode, input logic [3:0] op, input logic cin,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] e_z, input logic e_c, input logic verbose);
        @(posedge clk); #1;
        _reset = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_preset = 16'hAAAA;
        alu_mode = mode; alu_op = op; alu_c_in = cin; alu_x = x; alu_y = y;
        dmx_en = 1'b0; dmx_sel = 3'd5;
        push(id, hold_pc, e_z, e_c, 8'h00, verbose);
    endtask

    task automatic dmx_step(input int id, input logic en, input logic [2:0] sel,
                            input logic [7:0] e_dmx);
        @(posedge clk); #1;
        _reset = 1'b1; pc_inc = 1'b0; pc_load = 1'b0;
        alu_mode = 1'b1; alu_op = 4'h3; alu_c_in = 1'b0;
        dmx_en = en; dmx_sel = sel;
        push(id, hold_pc, 16'h0000, 1'b0, e_dmx, 1'b1);
    endtask

    task automatic cmp(input string nm, input int id, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, req);
        end
    endtask

    // Monitor: outputs are stable by the falling edge of each driven cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("pc", e.id, pc, e.pc);
            cmp("alu_z", e.id, alu_z, e.z);
            cmp("alu_c_out", e.id, 16'(alu_c_out), 16'(e.c));
            cmp("alu_zero", e.id, 16'(alu_zero), 16'(e.z == 16'h0000));
            cmp("zero_vs_z", e.id, 16'(alu_zero), 16'(alu_z == 16'h0000));
            cmp("dmx_out", e.id, 16'(dmx_out), 16'(e.dmx));
            if (e.verbose)
                $display("txn %0d: pc=%h z=%h c=%b zero=%b dmx=%h", e.id, pc, alu_z,
                         alu_c_out, alu_zero, dmx_out);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] logic_exp [16];
        logic [15:0] rx, ry;
        logic [3:0]  rop;
        logic        rmode, rcin;
        logic [16:0] r;
        int          wait_cnt;

        logic_exp = '{16'h0F0F, 16'h0303, 16'h0C0C, 16'h0000,
                      16'h3F3F, 16'h3333, 16'h3C3C, 16'h3030,
                      16'hCFCF, 16'hC3C3, 16'hCCCC, 16'hC0C0,
                      16'hFFFF, 16'hF3F3, 16'hFCFC, 16'hF0F0};

        // Reset, count, reset over load, load over inc, wrap, hold
        pc_step(0,  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        pc_step(1,  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        pc_step(2,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        pc_step(3,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001);
        pc_step(4,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0002);
        pc_step(5,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0003);
        pc_step(6,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0004);
        pc_step(7,  1'b0, 1'b1, 1'b1, 16'h1234, 16'h0005);
        pc_step(8,  1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000);
        pc_step(9,  1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
        pc_step(10, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        pc_step(11, 1'b1, 1'b0, 1'b1, 16'h00FE, 16'h0000);
        pc_step(12, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00FE);
        pc_step(13, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00FF);
        hold_pc = 16'h00FF;

        // Arithmetic directed vectors
        alu_step(20, 1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
        alu_step(21, 1'b0, 4'h6, 1'b1, 16'h1234, 16'h0034, 16'h1200, 1'b1, 1'b1);
        alu_step(22, 1'b0, 4'hF, 1'b0, 16'h0000, 16'h5555, 16'hFFFF, 1'b0, 1'b1);
        alu_step(23, 1'b0, 4'h6, 1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1);
        alu_step(24, 1'b0, 4'hC, 1'b1, 16'h8001, 16'h0000, 16'h0003, 1'b1, 1'b1);

        // Logic sweep with and without carry in
        for (int i = 0; i < 16; i++)
            alu_step(30 + i, 1'b1, 4'(i), 1'b0, 16'hF0F0, 16'hCCCC, logic_exp[i], 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            alu_step(50 + i, 1'b1, 4'(i), 1'b1, 16'hF0F0, 16'hCCCC, logic_exp[i], 1'b0, 1'b1);

        // Decoder
        for (int i = 0; i < 8; i++)
            dmx_step(70 + i, 1'b1, 3'(i), 8'h01 << i);
        for (int i = 0; i < 8; i++)
            dmx_step(80 + i, 1'b0, 3'(i), 8'h00);

        // Random ALU against the table model
        for (int i = 0; i < 10000; i++) begin
            rmode = 1'($urandom);
            rop   = 4'($urandom);
            rcin  = 1'($urandom);
            rx    = 16'($urandom);
            ry    = 16'($urandom);
            if (i % 16 == 0) ry = ~rx;
            r = alu_model(rmode, rop, rcin, rx, ry);
            alu_step(1000 + i, rmode, rop, rcin, rx, ry, r[15:0], r[16], 1'b0);
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
